rv32i_wb_stage: RTL and testbench

Writeback pipeline stage of the rv32i core. It registers the MEM-stage result and aligns and extends load data. It drives the register file write port (wb_enable, wb_reg, wb_data) and a forwarding copy of the same values. It also keeps a retired-instruction counter and flags misaligned or illegal loads.

---
 rtl/rv32i_wb_stage.sv | 145 ++++++++++++++
 tb/tb_rv32i_wb_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rv32i_wb_stage.sv
// rtl/rv32i_wb_stage.sv - rv32i writeback stage: result select, load align/extend, retire counter
//
// Purpose: registers the MEM-stage result, drives the register file write
// port plus a forwarding copy, flags misaligned/illegal loads and counts
// retired instructions.
//
// Ports:
//   clk, reset (async, active-low)
//   mem_*      : MEM-stage instruction (valid, pc, alu result/address,
//                raw load word, rd, rd write enable, result select, funct3)
//   stall      : hold the WB register
//   flush      : capture a bubble (beats stall)
//   wb_enable, wb_reg, wb_data : register file write port
//   fwd_valid  : bypass-mux valid, stays high across a stall
//   load_err   : one-cycle pulse for a faulting load
//   instret    : retired-instruction counter
module rv32i_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic [XLEN-1:0]  mem_pc,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rd_we,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic             stall,
  input  logic             flush,
  output logic             wb_enable,
  output logic [4:0]       wb_reg,
  output logic [XLEN-1:0]  wb_data,
  output logic             fwd_valid,
  output logic             load_err,
  output logic [CNT_W-1:0] instret
);

  logic             valid_q, valid_d;
  logic [4:0]       rd_q, rd_d;
  logic             rd_we_q, rd_we_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             err_q, err_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [1:0]       addr;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  result;
  logic             ld_err;

  // Load alignment and extension.
  always_comb begin
    addr     = mem_alu_result[1:0];
    byte_sel = 8'h00;
    case (addr)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel  = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = '0;
    case (mem_funct3)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_data = mem_rdata;
      3'd4:    load_data = {24'h0, byte_sel};
      3'd5:    load_data = {16'h0, half_sel};
      default: load_data = '0;
    endcase

    // funct3 3/6/7 are illegal; 1/5 (halfword) need addr[0]=0; LW needs addr=0.
    ld_err = mem_valid && (mem_wb_sel == 2'b01) &&
             ((mem_funct3 == 3'd3) || (mem_funct3[2:1] == 2'b11) ||
              ((mem_funct3[1:0] == 2'b01) && addr[0]) ||
              ((mem_funct3 == 3'd2) && (addr != 2'd0)));

    case (mem_wb_sel)
      2'b10:   result = mem_pc + XLEN'(4);
      2'b01:   result = load_data;
      default: result = mem_alu_result;
    endcase
  end

  // Next-state: flush > stall > capture. An invalid MEM slot is captured
  // as a bubble so stale rd/data never reach the write port.
  always_comb begin
    valid_d   = valid_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    data_d    = data_q;
    err_d     = err_q;
    first_d   = 1'b0;
    instret_d = instret_q;
    if (flush || (!stall && !mem_valid)) begin
      valid_d = 1'b0;
      rd_d    = '0;
      rd_we_d = 1'b0;
      data_d  = '0;
      err_d   = 1'b0;
    end else if (!stall) begin
      valid_d = 1'b1;
      rd_d    = mem_rd;
      rd_we_d = mem_rd_we;
      data_d  = ld_err ? '0 : result;
      err_d   = ld_err;
      first_d = 1'b1;
      // The counter moves together with the first WB cycle it accounts for.
      if (!ld_err) instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      data_q    <= data_d;
      err_q     <= err_d;
      first_q   <= first_d;
      instret_q <= instret_d;
    end
  end

  assign fwd_valid = valid_q && rd_we_q && (rd_q != 5'd0) && !err_q;
  assign wb_enable = fwd_valid && first_q;
  assign load_err  = valid_q && err_q && first_q;
  assign wb_reg    = rd_q;
  assign wb_data   = data_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_rv32i_wb_stage.sv
// tb/tb_rv32i_wb_stage.sv - self-checking bench for rv32i_wb_stage
module tb_rv32i_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_pc, mem_alu_result, mem_rdata;
  logic [4:0]  mem_rd;
  logic        mem_rd_we;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic        stall, flush;
  logic        wb_enable;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        fwd_valid, load_err;
  logic [63:0] instret;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_instret = 64'd0;

  always #5 clk = ~clk;

  rv32i_wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata), .mem_rd(mem_rd),
    .mem_rd_we(mem_rd_we), .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .stall(stall), .flush(flush), .wb_enable(wb_enable), .wb_reg(wb_reg),
    .wb_data(wb_data), .fwd_valid(fwd_valid), .load_err(load_err), .instret(instret)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] pc, alu, rdata;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic        stall, flush;
    logic        e_en;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        e_fwd, e_err, e_inc;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input string name, input logic valid, input logic [31:0] pc,
                              input logic [31:0] alu, input logic [31:0] rdata, input logic [4:0] rd,
                              input logic we, input logic [1:0] sel, input logic [2:0] f3,
                              input logic st, input logic fl, input logic e_en, input logic [4:0] e_reg,
                              input logic [31:0] e_data, input logic e_fwd, input logic e_err,
                              input logic e_inc);
    vec_t v;
    v.name = name; v.valid = valid; v.pc = pc; v.alu = alu; v.rdata = rdata; v.rd = rd;
    v.we = we; v.sel = sel; v.f3 = f3; v.stall = st; v.flush = fl; v.e_en = e_en;
    v.e_reg = e_reg; v.e_data = e_data; v.e_fwd = e_fwd; v.e_err = e_err; v.e_inc = e_inc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    mem_valid = v.valid; mem_pc = v.pc; mem_alu_result = v.alu; mem_rdata = v.rdata;
    mem_rd = v.rd; mem_rd_we = v.we; mem_wb_sel = v.sel; mem_funct3 = v.f3;
    stall = v.stall; flush = v.flush;
  endtask

  // Drive one vector, push its expectation, clock once, pop and compare.
  task automatic apply(input vec_t v);
    vec_t e;
    drive(v);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.e_inc) exp_instret = exp_instret + 64'd1;
    chk({e.name, ".wb_enable"}, 64'(wb_enable), 64'(e.e_en));
    chk({e.name, ".wb_reg"},    64'(wb_reg),    64'(e.e_reg));
    chk({e.name, ".wb_data"},   64'(wb_data),   64'(e.e_data));
    chk({e.name, ".fwd_valid"}, 64'(fwd_valid), 64'(e.e_fwd));
    chk({e.name, ".load_err"},  64'(load_err),  64'(e.e_err));
    chk({e.name, ".instret"},   instret,        exp_instret);
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".wb_enable"}, 64'(wb_enable), 64'd0);
    chk({name, ".wb_reg"},    64'(wb_reg),    64'd0);
    chk({name, ".wb_data"},   64'(wb_data),   64'd0);
    chk({name, ".fwd_valid"}, 64'(fwd_valid), 64'd0);
    chk({name, ".load_err"},  64'(load_err),  64'd0);
    chk({name, ".instret"},   instret,        64'd0);
  endtask

  localparam logic [31:0] RW = 32'h8081F0F1;

  initial begin
    //          name     v  pc            alu           rdata  rd we sel   f3 st fl  en reg data          fwd err inc
    tbl.push_back(mk("alu",    1, 32'h100,      32'h25,       0,  10, 1, 2'b00, 0, 0, 0,  1, 10, 32'h25,       1, 0, 1));
    tbl.push_back(mk("lb3",    1, 32'h104,      32'h1003,     RW, 3,  1, 2'b01, 0, 0, 0,  1, 3,  32'hFFFFFF80, 1, 0, 1));
    tbl.push_back(mk("lbu3",   1, 32'h108,      32'h1003,     RW, 3,  1, 2'b01, 4, 0, 0,  1, 3,  32'h00000080, 1, 0, 1));
    tbl.push_back(mk("lh2",    1, 32'h10C,      32'h1002,     RW, 4,  1, 2'b01, 1, 0, 0,  1, 4,  32'hFFFF8081, 1, 0, 1));
    tbl.push_back(mk("lhu0",   1, 32'h110,      32'h1000,     RW, 4,  1, 2'b01, 5, 0, 0,  1, 4,  32'h0000F0F1, 1, 0, 1));
    tbl.push_back(mk("lw0",    1, 32'h114,      32'h1000,     RW, 8,  1, 2'b01, 2, 0, 0,  1, 8,  32'h8081F0F1, 1, 0, 1));
    tbl.push_back(mk("lb1",    1, 32'h118,      32'h1001,     RW, 8,  1, 2'b01, 0, 0, 0,  1, 8,  32'hFFFFFFF0, 1, 0, 1));
    tbl.push_back(mk("lh0",    1, 32'h11C,      32'h1000,     RW, 9,  1, 2'b01, 1, 0, 0,  1, 9,  32'hFFFFF0F1, 1, 0, 1));
    tbl.push_back(mk("lbu0",   1, 32'h120,      32'h1000,     RW, 9,  1, 2'b01, 4, 0, 0,  1, 9,  32'h000000F1, 1, 0, 1));
    tbl.push_back(mk("lw_mis", 1, 32'h124,      32'h1002,     RW, 7,  1, 2'b01, 2, 0, 0,  0, 7,  32'h0,        0, 1, 0));
    tbl.push_back(mk("x0",     1, 32'h128,      32'h141,      0,  0,  1, 2'b00, 0, 0, 0,  0, 0,  32'h141,      0, 0, 1));
    tbl.push_back(mk("jal",    1, 32'hFFFFFFFC, 32'h5,        0,  1,  1, 2'b10, 0, 0, 0,  1, 1,  32'h0,        1, 0, 1));
    tbl.push_back(mk("sel11",  1, 32'h130,      32'hDEAD,     RW, 4,  1, 2'b11, 6, 0, 0,  1, 4,  32'hDEAD,     1, 0, 1));
    tbl.push_back(mk("lh_mis", 1, 32'h134,      32'h1001,     RW, 6,  1, 2'b01, 1, 0, 0,  0, 6,  32'h0,        0, 1, 0));
    tbl.push_back(mk("ld_f3",  1, 32'h138,      32'h1000,     RW, 6,  1, 2'b01, 3, 0, 0,  0, 6,  32'h0,        0, 1, 0));
    tbl.push_back(mk("nowe",   1, 32'h13C,      32'h77,       0,  12, 0, 2'b00, 0, 0, 0,  0, 12, 32'h77,       0, 0, 1));
    tbl.push_back(mk("bubble", 0, 32'h140,      32'h99,       0,  13, 1, 2'b00, 0, 0, 0,  0, 0,  32'h0,        0, 0, 0));

    reset = 1'b0;
    drive(mk("idle", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Stall: write once, forward throughout, counter moves once.
    apply(mk("cap5",   1, 32'h200, 32'h20, 0, 5, 1, 2'b00, 0, 0, 0, 1, 5, 32'h20, 1, 0, 1));
    for (int i = 0; i < 3; i++)
      apply(mk("stall",  1, 32'h204, 32'h99, 0, 9, 1, 2'b00, 0, 1, 0, 0, 5, 32'h20, 1, 0, 0));
    apply(mk("stflush", 1, 32'h204, 32'h99, 0, 9, 1, 2'b00, 0, 1, 1, 0, 0, 32'h0, 0, 0, 0));

    // Faulting load held by a stall: load_err pulses only once.
    apply(mk("errcap", 1, 32'h208, 32'h1003, RW, 11, 1, 2'b01, 2, 0, 0, 0, 11, 32'h0, 0, 1, 0));
    apply(mk("errst",  1, 32'h20C, 32'h44,   0,  2,  1, 2'b00, 0, 1, 0, 0, 11, 32'h0, 0, 0, 0));
    // Flush alone beats a valid MEM instruction.
    apply(mk("flush",  1, 32'h210, 32'h55,   0,  2,  1, 2'b00, 0, 0, 1, 0, 0,  32'h0, 0, 0, 0));

    // Asynchronous reset between edges while a write is in flight.
    apply(mk("prerst", 1, 32'h214, 32'h77, 0, 6, 1, 2'b00, 0, 0, 0, 1, 6, 32'h77, 1, 0, 1));
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    reset = 1'b1;
    exp_instret = 64'd0;
    apply(mk("postrst", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    apply(mk("after",  1, 32'h300, 32'h1, 0, 3, 1, 2'b00, 0, 0, 0, 1, 3, 32'h1, 1, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
